irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: 4-source exception controller. It holds pending request bits,
// applies a mask, and dispatches the highest-priority unmasked source
// (bit0 first) to a fixed vector. One exception is serviced at a time:
// IDLE -> VECTOR (one-cycle redirect) -> HANDLER -> IDLE on rti.

// One sticky pending bit. A new request in the same cycle as its clear wins.
module irq_ctrl_pend_bit (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic clr,
  output logic q
);

  // Set on request, drop on dispatch clear, unless re-requested this cycle
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= req | (q & ~clr);
  end

endmodule

module irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int PC_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_mask,
  input  logic               stall,
  input  logic               miss,
  input  logic [PC_W-1:0]    cur_pc,
  input  logic               rti,
  output logic               vec_valid,
  output logic [PC_W-1:0]    vec_addr,
  output logic [PC_W-1:0]    epc,
  output logic [1:0]         cause,
  output logic               in_handler,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VECTOR  = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pend_act;
  logic [NUM_SRC-1:0] clr_vec;
  logic [1:0]         win_idx;
  logic               grant;

  // Fixed handler table; sources 1 and 3 share a handler
  function automatic logic [PC_W-1:0] vec_of(input logic [1:0] idx);
    case (idx)
      2'd0:    vec_of = 16'h0030;
      2'd1:    vec_of = 16'h0090;
      2'd2:    vec_of = 16'h0100;
      default: vec_of = 16'h0090;
    endcase
  endfunction

  // Pending bits live in per-source cells; the register value is the output
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_pend
    irq_ctrl_pend_bit u_pend (
      .clk (clk),
      .rst (rst),
      .req (src_req[g]),
      .clr (clr_vec[g]),
      .q   (pending[g])
    );
  end

  // Grant uses the registered mask, so a mask write only takes effect next cycle
  assign pend_act = pending & ~mask;
  assign grant    = (state_q == IDLE) && (|pend_act) && !stall && !miss;

  // Lowest-index active source wins: scan high to low, last hit sticks
  always_comb begin
    win_idx = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (pend_act[i]) win_idx = 2'(i);
  end

  // Clear only the dispatched source
  always_comb begin
    clr_vec = '0;
    if (grant) clr_vec[win_idx] = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: VECTOR lasts exactly one cycle; no dispatch from HANDLER
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = VECTOR;
      VECTOR:  state_d = HANDLER;
      HANDLER: if (rti)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    vec_valid  = 1'b0;
    in_handler = 1'b0;
    case (state_q)
      VECTOR:  vec_valid  = 1'b1;
      HANDLER: in_handler = 1'b1;
      default: ;
    endcase
  end

  // Mask register; resets to all-masked
  always_ff @(posedge clk) begin
    if (rst)         mask <= '1;
    else if (cfg_we) mask <= cfg_mask;
  end

  // Exception context captured on grant, held until the next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      epc      <= '0;
      cause    <= '0;
      vec_addr <= '0;
    end else if (grant) begin
      epc      <= cur_pc;
      cause    <= win_idx;
      vec_addr <= vec_of(win_idx);
    end
  end

endmodule
